// File: rtl/klein_pkg.sv
// Shared constants, block type and collector FSM states for the KLEIN-96
// output path.
package klein_pkg;

  localparam int BYTE_W  = 8;
  localparam int BLOCK_W = 64;
  localparam int NBYTES  = 8;

  // Bit 0 is the MSB; byte k occupies bits [8k:8k+7].
  typedef logic [0:BLOCK_W-1] klein_block_t;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

endpackage

// File: rtl/klein_blk_fifo.sv
// First-word-fall-through block FIFO. A push into a full FIFO is accepted
// when a pop happens in the same cycle.
module klein_blk_fifo
  import klein_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         push,
  input  klein_block_t din,
  input  logic         pop,
  output klein_block_t dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  klein_block_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_FULL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Masked so the output reads zero whenever nothing is held.
  assign dout    = empty ? '0 : mem_q[rd_q];

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge ck) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/klein_96_collect.sv
// Collects the KLEIN-96 core's eight serial ciphertext bytes into 64-bit
// blocks and queues them for a valid/ready consumer.
module klein_96_collect
  import klein_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic               ck,
  input  logic               rst_n,
  input  logic               core_ready,
  input  logic [0:BYTE_W-1]  core_out,
  input  logic               ct_ready,
  output logic               ct_valid,
  output logic [0:BLOCK_W-1] ct_data,
  output logic               busy,
  output logic               overflow,
  output logic [CNT_W-1:0]   blk_cnt
);

  localparam int ASM_W = BLOCK_W - BYTE_W;

  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [0:ASM_W-1]    asm_q, asm_d;
  logic                core_ready_q;
  logic                overflow_q;
  logic [CNT_W-1:0]    blk_cnt_q;
  logic                start_ev, blk_done, pop, push_ok, fifo_full, fifo_empty;
  klein_block_t        blk;

  assign start_ev = core_ready & ~core_ready_q;
  assign pop      = ct_valid & ct_ready;
  assign push_ok  = blk_done & (~fifo_full | pop);
  // The final byte goes straight into the block; only bytes 0..6 are stored.
  assign blk      = {asm_q, core_out};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    asm_d    = asm_q;
    blk_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ev) begin
          asm_d   = {asm_q[BYTE_W:ASM_W-1], core_out};
          idx_d   = 3'd1;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'(NBYTES - 1)) begin
          blk_done = 1'b1;
          state_d  = IDLE;
        end else begin
          asm_d = {asm_q[BYTE_W:ASM_W-1], core_out};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      core_ready_q <= 1'b0;
      overflow_q   <= 1'b0;
      blk_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      core_ready_q <= core_ready;
      if (blk_done && !push_ok) overflow_q <= 1'b1;
      if (push_ok)              blk_cnt_q  <= blk_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ck) begin
    asm_q <= asm_d;
  end

  klein_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .ck    (ck),
    .rst_n (rst_n),
    .push  (push_ok),
    .din   (blk),
    .pop   (pop),
    .dout  (ct_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ct_valid = ~fifo_empty;
  assign busy     = (state_q == COLLECT);
  assign overflow = overflow_q;
  assign blk_cnt  = blk_cnt_q;

endmodule

// File: tb/tb_klein_96_collect.sv
// Scoreboard bench for klein_96_collect: stimulus queues expected blocks,
// a negedge monitor pops and compares on every accepted output.
module tb_klein_96_collect;

  localparam int CNT_W = 4;

  logic             ck = 1'b0;
  logic             rst_n = 1'b1;
  logic             core_ready;
  logic [0:7]       core_out;
  logic             ct_ready;
  logic             ct_valid;
  logic [0:63]      ct_data;
  logic             busy;
  logic             overflow;
  logic [CNT_W-1:0] blk_cnt;

  int          total = 0;
  int          passed = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_blk;

  klein_96_collect #(.DEPTH(2), .CNT_W(CNT_W)) dut (
    .ck         (ck),
    .rst_n      (rst_n),
    .core_ready (core_ready),
    .core_out   (core_out),
    .ct_ready   (ct_ready),
    .ct_valid   (ct_valid),
    .ct_data    (ct_data),
    .busy       (busy),
    .overflow   (overflow),
    .blk_cnt    (blk_cnt)
  );

  always #5 ck = ~ck;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%h, required 0x%h", nm, act, req);
  endtask

  // Monitor: every handshake seen here is a pop at the following posedge.
  always @(negedge ck) begin
    if (rst_n === 1'b1 && ct_valid === 1'b1 && ct_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_block: got 0x%h, required no block", ct_data);
      end else begin
        exp_blk = exp_q.pop_front();
        chk("block_data", 64'(ct_data), exp_blk);
      end
    end
  end

  task automatic send_block(input logic [63:0] blk, input bit keep);
    if (keep) exp_q.push_back(blk);
    @(posedge ck); #1;
    core_ready = 1'b1;
    core_out   = blk[63:56];
    for (int k = 1; k < 8; k++) begin
      @(posedge ck); #1;
      core_ready = 1'b0;
      core_out   = blk[63-8*k -: 8];
    end
  endtask

  task automatic do_reset();
    core_ready = 1'b0;
    ct_ready   = 1'b0;
    @(posedge ck); #3;
    rst_n = 1'b0;
    exp_q.delete();
    #10;
    rst_n = 1'b1;
  endtask

  initial begin
    core_ready = 1'b0;
    core_out   = '0;
    ct_ready   = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_ct_valid", 64'(ct_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_blk_cnt", 64'(blk_cnt), 64'd0);
    chk("rst_ct_data", 64'(ct_data), 64'd0);
    rst_n = 1'b1;

    // Basic block, 8-cycle latency
    ct_ready = 1'b1;
    send_block(64'h0102030405060708, 1'b1);
    chk("basic_busy_mid", 64'(busy), 64'd1);
    @(posedge ck); #1;
    chk("basic_valid", 64'(ct_valid), 64'd1);
    chk("basic_data", 64'(ct_data), 64'h0102030405060708);
    chk("basic_busy_done", 64'(busy), 64'd0);
    chk("basic_blk_cnt", 64'(blk_cnt), 64'd1);
    repeat (3) @(posedge ck);

    // Backpressure: third block dropped
    do_reset();
    send_block(64'hA0A1A2A3A4A5A6A7, 1'b1);
    send_block(64'hB0B1B2B3B4B5B6B7, 1'b1);
    send_block(64'hC0C1C2C3C4C5C6C7, 1'b0);
    @(posedge ck); #1;
    chk("bp_overflow", 64'(overflow), 64'd1);
    chk("bp_blk_cnt", 64'(blk_cnt), 64'd2);
    chk("bp_valid", 64'(ct_valid), 64'd1);
    repeat (2) @(posedge ck);
    #1 chk("bp_hold_data", 64'(ct_data), 64'hA0A1A2A3A4A5A6A7);
    ct_ready = 1'b1;
    repeat (3) @(posedge ck);
    #1;
    chk("bp_drained", 64'(ct_valid), 64'd0);
    chk("bp_overflow_sticky", 64'(overflow), 64'd1);

    // Full FIFO with pop on the completing edge
    do_reset();
    send_block(64'h1122334455667788, 1'b1);
    send_block(64'h99AABBCCDDEEFF00, 1'b1);
    send_block(64'h0F1E2D3C4B5A6978, 1'b1);
    ct_ready = 1'b1;
    @(posedge ck); #1;
    ct_ready = 1'b0;
    chk("fp_overflow", 64'(overflow), 64'd0);
    chk("fp_blk_cnt", 64'(blk_cnt), 64'd3);
    chk("fp_head", 64'(ct_data), 64'h99AABBCCDDEEFF00);
    ct_ready = 1'b1;
    repeat (3) @(posedge ck);
    #1 chk("fp_drained", 64'(ct_valid), 64'd0);

    // core_ready held high for 20 cycles
    do_reset();
    ct_ready = 1'b1;
    exp_q.push_back(64'h1011121314151617);
    @(posedge ck); #1;
    core_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      core_out = 8'(8'h10 + i);
      @(posedge ck); #1;
    end
    core_ready = 1'b0;
    chk("lvl_blk_cnt", 64'(blk_cnt), 64'd1);
    chk("lvl_busy", 64'(busy), 64'd0);
    send_block(64'h5A5B5C5D5E5F6061, 1'b1);
    @(posedge ck); #1;
    chk("lvl_retrigger_cnt", 64'(blk_cnt), 64'd2);

    // Asynchronous reset in the middle of a block
    do_reset();
    send_block(64'hDEADBEEFCAFEF00D, 1'b0);
    @(posedge ck); #1;
    core_ready = 1'b1;
    core_out   = 8'hC0;
    for (int k = 1; k < 4; k++) begin
      @(posedge ck); #1;
      core_ready = 1'b0;
      core_out   = 8'(8'hC0 + k);
    end
    @(posedge ck); #3;
    chk("mid_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(ct_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_blk_cnt", 64'(blk_cnt), 64'd0);
    chk("mid_rst_data", 64'(ct_data), 64'd0);
    exp_q.delete();
    #3 rst_n = 1'b1;
    ct_ready = 1'b1;
    send_block(64'h0123456789ABCDEF, 1'b1);
    @(posedge ck); #1;
    chk("mid_clean_data", 64'(ct_data), 64'h0123456789ABCDEF);
    chk("mid_clean_cnt", 64'(blk_cnt), 64'd1);

    // Counter wrap with a 4-bit counter
    do_reset();
    ct_ready = 1'b1;
    for (int i = 0; i < 17; i++)
      send_block(64'(i + 1) * 64'h0101010101010101, 1'b1);
    @(posedge ck); #1;
    chk("wrap_blk_cnt", 64'(blk_cnt), 64'd1);
    chk("wrap_overflow", 64'(overflow), 64'd0);

    repeat (4) @(posedge ck);
    #1 chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/klein_96_collect.md
# klein_96_collect

Byte-serial output collector for the serial KLEIN-96 core. It sits directly downstream of the core and watches the core's ready strobe and 8-bit output bus. It reassembles the eight ciphertext bytes into one 64-bit block and buffers completed blocks in a small FIFO. Blocks are presented to the consumer through a valid/ready handshake, with overflow and block-count status.

## Interface
- DEPTH, 2: number of 64-bit blocks buffered (power of two, ≥2).
- CNT_W, 16: width of the completed-block counter.

- ck  in  1  rising-edge clock, shared with the KLEIN-96 core.
- rst_n  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- core_ready  in  1  core ready level; a 0→1 transition marks ciphertext byte 0 on core_out in the same cycle.
- core_out  in  [0:7]  core serial ciphertext byte.
- ct_ready  in  1  consumer accepts the head block.
- ct_valid  out  1  head block available.
- ct_data  out  [0:63]  head block; byte k occupies bits [8k:8k+7] (bit 0 = MSB).
- busy  out  1  collection in progress.
- overflow  out  1  sticky: a completed block was dropped.
- blk_cnt  out  [CNT_W-1:0]  count of blocks written into the FIFO; wraps modulo 2^CNT_W.

## Operation
- Edge detection: a registered copy of core_ready is kept. start_ev = core_ready & ~core_ready_q.
- FSM states:
  - IDLE: on start_ev, capture core_out into byte 0, set idx=1, go to COLLECT.
  - COLLECT: each cycle, capture core_out into byte idx and increment idx.
    - When idx==7 is captured, assemble the block, push it to the FIFO, and return to IDLE.
- start_ev while in COLLECT is ignored; the current block continues.
- The core guarantees bytes 1..7 arrive on the seven cycles after byte 0, with no gaps.
- FIFO push:
  - If the FIFO is not full, or is full with a simultaneous pop (ct_valid & ct_ready in the same cycle), the block is stored and blk_cnt increments.
  - Otherwise the block is discarded, overflow sets, and blk_cnt is unchanged.
- FIFO pop: a pop occurs when ct_valid & ct_ready. ct_data then advances to the next entry, or ct_valid drops if the FIFO is empty.
- ct_data is held stable while ct_valid=1 and ct_ready=0.
- overflow clears only on reset.
- Reset mid-collection: the partial block is discarded, the FSM returns to IDLE, and core_ready_q clears to 0.
  - Consequence: if core_ready is still high when reset is released, the first clock edge sees start_ev.

## Timing
- Reset values:
  - ct_valid=0, busy=0, overflow=0, blk_cnt=0.
  - ct_data=0.
  - FSM=IDLE, FIFO empty.
- Byte capture: byte 0 is sampled at edge T (the first edge at which core_ready=1 after being 0). Bytes 1..7 are sampled at edges T+1..T+7.
- busy is 1 from after edge T through edge T+7, and 0 after edge T+7.
- Push occurs at edge T+7.
  - If the FIFO was empty, ct_valid=1 and ct_data=block are visible after edge T+7.
  - Latency from byte 0 to valid output is 8 cycles.
- ct_valid is registered; no combinational path from core_ready or ct_ready to ct_valid.
- Sustained throughput: one block per 8 cycles with ct_ready tied high; no drops.

## Structure
- Package klein_pkg holds:
  - constants BYTE_W=8, BLOCK_W=64, NBYTES=8;
  - typedef klein_block_t (logic [0:63]);
  - FSM state enum (IDLE, COLLECT).
- Sub-module klein_blk_fifo: synchronous FIFO of klein_block_t, DEPTH entries. Ports: push, din, pop, dout, full, empty.
  - Read is first-word-fall-through.
  - Simultaneous push+pop is legal when full.
- The top level holds the edge detector, FSM, byte index counter, assembly register, overflow flag and blk_cnt.

## Test plan
- Basic: ct_ready=1; core_ready rises with bytes 01,02,…,08 on consecutive cycles. Required: ct_data=0x0102030405060708 with ct_valid after the 8th edge, and blk_cnt=1.
- Backpressure: ct_ready=0; send three blocks A, B, C (DEPTH=2). Required: A and B retained in order, C dropped, overflow=1, blk_cnt=2. Raising ct_ready then yields A then B on successive cycles.
- Full with simultaneous pop: FIFO full; ct_ready pulses exactly at the edge where the third block completes. Required: no overflow, blk_cnt=3, order preserved.
- Level-held ready: core_ready stays high for 20 cycles. Required: exactly one block captured; no retrigger until core_ready falls and rises again.
- Reset mid-collection: assert rst_n=0 after byte 3 of a block. Required: all outputs reset immediately (asynchronously) and no block is emitted. The next clean 8-byte sequence produces the correct block with blk_cnt=1.
- Counter wrap: with CNT_W=4, push 17 blocks with ct_ready=1. Required: blk_cnt=1 and overflow=0.
